// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter with prioritised redirects, stall support and a
// direct-mapped branch target buffer built from 2-bit saturating counters.
module pc_fetch_unit #(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = 32'h0000_3000,
    parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h0000_4180,
    parameter int unsigned        BTB_IDX_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall,
    input  logic              exc_req,
    input  logic              ex_redirect,
    input  logic [ADDR_W-1:0] ex_redirect_addr,
    input  logic              id_jump,
    input  logic [ADDR_W-1:0] id_jump_addr,
    input  logic              btb_upd_en,
    input  logic [ADDR_W-1:0] btb_upd_pc,
    input  logic [ADDR_W-1:0] btb_upd_target,
    input  logic              btb_upd_taken,
    output logic [ADDR_W-1:0] pc,
    output logic              im_read_en,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target
);

    localparam int unsigned ENTRIES = 1 << BTB_IDX_W;
    localparam int unsigned TAG_W   = ADDR_W - BTB_IDX_W - 2;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic {
        StBoot,
        StRun
    } state_t;

    state_t state;

    logic              btb_valid  [ENTRIES];
    logic [TAG_W-1:0]  btb_tag    [ENTRIES];
    logic [ADDR_W-1:0] btb_target [ENTRIES];
    logic [1:0]        btb_ctr    [ENTRIES];

    logic [BTB_IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0]     lk_tag;
    logic                 lk_hit;
    logic [BTB_IDX_W-1:0] up_idx;
    logic [TAG_W-1:0]     up_tag;
    logic                 up_hit;
    logic [ADDR_W-1:0]    pc_next;
    logic                 unused_upd_lsbs;

    // Word offset of the update address never selects an entry.
    assign unused_upd_lsbs = ^btb_upd_pc[1:0];

    // Lookup is on the registered pc only, so the outputs never see redirect inputs.
    always_comb begin
        lk_idx = pc[BTB_IDX_W+1:2];
        lk_tag = pc[ADDR_W-1:BTB_IDX_W+2];
        lk_hit = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
        pred_taken  = im_read_en && lk_hit && btb_ctr[lk_idx][1];
        pred_target = (im_read_en && lk_hit) ? btb_target[lk_idx] : '0;
    end

    always_comb begin
        up_idx = btb_upd_pc[BTB_IDX_W+1:2];
        up_tag = btb_upd_pc[ADDR_W-1:BTB_IDX_W+2];
        up_hit = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);
    end

    always_comb begin
        pc_next = pc + ADDR_W'(4);
        if (exc_req) begin
            pc_next = EXC_VEC & ALIGN_MASK;
        end else if (ex_redirect) begin
            pc_next = ex_redirect_addr & ALIGN_MASK;
        end else if (id_jump) begin
            pc_next = id_jump_addr & ALIGN_MASK;
        end else if (stall) begin
            pc_next = pc;
        end else if (pred_taken) begin
            pc_next = pred_target;
        end
    end

    // The boot edge still loads RESET_VEC, so the first fetch is at the reset vector.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= StBoot;
            pc         <= RESET_VEC;
            im_read_en <= 1'b0;
        end else begin
            case (state)
                StBoot: begin
                    state      <= StRun;
                    pc         <= RESET_VEC;
                    im_read_en <= 1'b1;
                end
                default: begin
                    state      <= StRun;
                    pc         <= pc_next;
                    im_read_en <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
            end
        end else if (state == StRun && btb_upd_en) begin
            if (up_hit) begin
                if (btb_upd_taken) begin
                    if (btb_ctr[up_idx] != 2'b11) begin
                        btb_ctr[up_idx] <= btb_ctr[up_idx] + 2'd1;
                    end
                    btb_target[up_idx] <= btb_upd_target & ALIGN_MASK;
                end else if (btb_ctr[up_idx] != 2'b00) begin
                    btb_ctr[up_idx] <= btb_ctr[up_idx] - 2'd1;
                end
            end else if (btb_upd_taken) begin
                btb_valid[up_idx]  <= 1'b1;
                btb_tag[up_idx]    <= up_tag;
                btb_target[up_idx] <= btb_upd_target & ALIGN_MASK;
                btb_ctr[up_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed plan with literal expectations, then random
// traffic checked every cycle against a behavioural model of the fetch unit.
module tb_pc_fetch_unit;

    localparam int unsigned ENTRIES   = 16;
    localparam logic [31:0] RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC   = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rstn, stall, exc_req, ex_redirect, id_jump, btb_upd_en, btb_upd_taken;
    logic [31:0] ex_redirect_addr, id_jump_addr, btb_upd_pc, btb_upd_target;
    logic [31:0] pc, pred_target;
    logic        im_read_en, pred_taken;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .ADDR_W   (32),
        .RESET_VEC(RESET_VEC),
        .EXC_VEC  (EXC_VEC),
        .BTB_IDX_W(4)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .stall           (stall),
        .exc_req         (exc_req),
        .ex_redirect     (ex_redirect),
        .ex_redirect_addr(ex_redirect_addr),
        .id_jump         (id_jump),
        .id_jump_addr    (id_jump_addr),
        .btb_upd_en      (btb_upd_en),
        .btb_upd_pc      (btb_upd_pc),
        .btb_upd_target  (btb_upd_target),
        .btb_upd_taken   (btb_upd_taken),
        .pc              (pc),
        .im_read_en      (im_read_en),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target)
    );

    // Behavioural model: each BTB slot remembers the full address of the branch that owns it.
    bit          m_known = 1'b0;
    bit          m_run   = 1'b0;
    logic [31:0] m_pc    = '0;
    bit          m_valid [ENTRIES];
    logic [31:0] m_owner [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];

    function automatic int slot_of(input logic [31:0] a);
        return int'((a / 4) % ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        int s = slot_of(a);
        return m_valid[s] && ((m_owner[s] / 64) == (a / 64));
    endfunction

    function automatic bit exp_pt();
        return m_run && m_hit(m_pc) && (m_ctr[slot_of(m_pc)] >= 2);
    endfunction

    function automatic logic [31:0] exp_ptgt();
        return (m_run && m_hit(m_pc)) ? m_tgt[slot_of(m_pc)] : 32'h0;
    endfunction

    task automatic model_step();
        logic [31:0] nxt;
        int s;
        if (!rstn) begin
            m_known = 1'b1;
            m_run   = 1'b0;
            m_pc    = RESET_VEC;
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
        end else if (m_known && !m_run) begin
            m_run = 1'b1;
            m_pc  = RESET_VEC;
        end else if (m_known) begin
            if (exc_req)          nxt = EXC_VEC & ~32'h3;
            else if (ex_redirect) nxt = ex_redirect_addr & ~32'h3;
            else if (id_jump)     nxt = id_jump_addr & ~32'h3;
            else if (stall)       nxt = m_pc;
            else if (exp_pt())    nxt = exp_ptgt();
            else                  nxt = m_pc + 32'd4;
            if (btb_upd_en) begin
                s = slot_of(btb_upd_pc);
                if (m_hit(btb_upd_pc)) begin
                    if (btb_upd_taken) begin
                        m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                        m_tgt[s] = btb_upd_target & ~32'h3;
                    end else begin
                        m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
                    end
                end else if (btb_upd_taken) begin
                    m_valid[s] = 1'b1;
                    m_owner[s] = btb_upd_pc;
                    m_tgt[s]   = btb_upd_target & ~32'h3;
                    m_ctr[s]   = 2;
                end
            end
            m_pc = nxt;
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single compare process: outputs depend only on registered state, so the falling edge is safe.
    always @(negedge clk) begin
        if (m_known) begin
            cmp("model pc", pc, m_pc);
            cmp("model im_read_en", 32'(im_read_en), 32'(m_run));
            cmp("model pred_taken", 32'(pred_taken), 32'(exp_pt()));
            cmp("model pred_target", pred_target, exp_ptgt());
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        stall = 0; exc_req = 0; ex_redirect = 0; id_jump = 0;
        btb_upd_en = 0; btb_upd_taken = 0;
        ex_redirect_addr = '0; id_jump_addr = '0; btb_upd_pc = '0; btb_upd_target = '0;
    endtask

    task automatic jump_to(input logic [31:0] a);
        id_jump = 1; id_jump_addr = a;
        tick();
        id_jump = 0;
    endtask

    task automatic btb_update(input logic [31:0] a, input logic [31:0] t, input logic tk);
        btb_upd_en = 1; btb_upd_pc = a; btb_upd_target = t; btb_upd_taken = tk;
        tick();
        btb_upd_en = 0;
    endtask

    function automatic logic [31:0] pool_addr();
        if ($urandom_range(0, 15) == 0) return $urandom;
        return 32'h0000_3000 + 32'($urandom_range(0, 63)) * 4;
    endfunction

    initial begin
        clear_inputs();
        rstn = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("reset im_read_en", 32'(im_read_en), 32'h0);
            cmp("reset pc", pc, 32'h0000_3000);
            cmp("reset pred_taken", 32'(pred_taken), 32'h0);
        end
        rstn = 1;
        tick();
        cmp("boot im_read_en", 32'(im_read_en), 32'h1);
        cmp("boot pc", pc, 32'h0000_3000);
        tick();
        cmp("run pc1", pc, 32'h0000_3004);
        tick();
        cmp("run pc2", pc, 32'h0000_3008);

        stall = 1;
        tick();
        cmp("stall hold 1", pc, 32'h0000_3008);
        tick();
        cmp("stall hold 2", pc, 32'h0000_3008);
        id_jump = 1; id_jump_addr = 32'h0000_3103;
        tick();
        cmp("jump over stall", pc, 32'h0000_3100);
        clear_inputs();

        ex_redirect = 1; ex_redirect_addr = 32'hFFFF_FFF8;
        tick();
        clear_inputs();
        tick();
        cmp("wrap pc1", pc, 32'hFFFF_FFFC);
        tick();
        cmp("wrap pc2", pc, 32'h0000_0000);
        tick();
        cmp("wrap pc3", pc, 32'h0000_0004);

        exc_req = 1; ex_redirect = 1; ex_redirect_addr = 32'h5000;
        id_jump = 1; id_jump_addr = 32'h6000;
        tick();
        cmp("exc priority", pc, 32'h0000_4180);
        exc_req = 0;
        tick();
        cmp("ex over id", pc, 32'h0000_5000);
        clear_inputs();

        btb_update(32'h3010, 32'h3040, 1);
        jump_to(32'h3010);
        cmp("btb alloc pred", 32'(pred_taken), 32'h1);
        cmp("btb alloc target", pred_target, 32'h0000_3040);
        tick();
        cmp("btb follow", pc, 32'h0000_3040);
        btb_update(32'h3010, 32'h3040, 0);
        btb_update(32'h3010, 32'h3040, 0);
        jump_to(32'h3010);
        cmp("btb ctr 00", 32'(pred_taken), 32'h0);
        tick();
        cmp("btb fallthrough", pc, 32'h0000_3014);
        btb_update(32'h3010, 32'h3040, 1);
        jump_to(32'h3010);
        cmp("btb ctr 01", 32'(pred_taken), 32'h0);
        btb_update(32'h3010, 32'h3040, 1);
        jump_to(32'h3010);
        cmp("btb ctr 10", 32'(pred_taken), 32'h1);

        btb_update(32'h3050, 32'h3080, 0);
        jump_to(32'h3010);
        cmp("alias kept", 32'(pred_taken), 32'h1);
        rstn = 0;
        tick();
        rstn = 1;
        tick();
        jump_to(32'h3010);
        cmp("btb cleared", 32'(pred_taken), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            clear_inputs();
            rstn             = ($urandom_range(0, 299) != 0);
            exc_req          = ($urandom_range(0, 39) == 0);
            ex_redirect      = ($urandom_range(0, 19) == 0);
            ex_redirect_addr = pool_addr() | 32'($urandom_range(0, 3));
            id_jump          = ($urandom_range(0, 9) == 0);
            id_jump_addr     = pool_addr() | 32'($urandom_range(0, 3));
            stall            = ($urandom_range(0, 5) == 0);
            btb_upd_en       = ($urandom_range(0, 2) == 0);
            btb_upd_pc       = pool_addr();
            btb_upd_target   = pool_addr() | 32'($urandom_range(0, 3));
            btb_upd_taken    = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
